axi_sram_slave: RTL



---
 rtl/axi_sram_slave_if.sv | 46 ++++
 rtl/axi_sram_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the L2 master and the SRAM slave.
// Only the channels the SRAM slave uses are carried.
interface axi4_interface #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]                  m_awlen;
    logic                        m_awvalid;
    logic                        s_awready;

    logic [AXI_DATA_WIDTH-1:0]   m_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] m_wstrb;
    logic                        m_wlast;
    logic                        m_wvalid;
    logic                        s_wready;

    logic                        s_bvalid;
    logic                        m_bready;

    logic [AXI_ADDR_WIDTH-1:0]   m_araddr;
    logic [7:0]                  m_arlen;
    logic                        m_arvalid;
    logic                        s_arready;

    logic [AXI_DATA_WIDTH-1:0]   s_rdata;
    logic                        s_rvalid;
    logic                        s_rlast;
    logic                        m_rready;

    modport master (
        output m_awaddr, m_awlen, m_awvalid, input s_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid, input s_wready,
        input s_bvalid, output m_bready,
        output m_araddr, m_arlen, m_arvalid, input s_arready,
        input s_rdata, s_rvalid, s_rlast, output m_rready
    );

    modport slave (
        input m_awaddr, m_awlen, m_awvalid, output s_awready,
        input m_wdata, m_wstrb, m_wlast, m_wvalid, output s_wready,
        output s_bvalid, input m_bready,
        input m_araddr, m_arlen, m_arvalid, output s_arready,
        output s_rdata, s_rvalid, s_rlast, input m_rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by on-chip SRAM; one INCR burst (read or write) at a time.
// Writes have priority over reads in IDLE. Burst addresses wrap within the SRAM.
// Optional build macro AXI_SRAM_WRITE_STROBE_EN: honour m_wstrb per byte;
// otherwise every write beat stores the full word.
module axi_sram_slave #(
    parameter int unsigned MEM_SIZE = 'h40000
) (
    input  logic          clk,
    input  logic          reset,
    axi4_interface.slave  axi_bus
);
    localparam int unsigned ADDR_WIDTH     = $clog2(MEM_SIZE);
    localparam int unsigned AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        WRITE_RESP,
        READ_BURST
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_rst_done;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    logic [ADDR_WIDTH-1:0]     w_aw_idx;
    logic [ADDR_WIDTH-1:0]     w_ar_idx;
    logic                      w_awready;
    logic                      w_arready;
    logic                      w_wready;
    logic                      w_bvalid;
    logic                      w_rvalid;
    logic                      w_rlast;
    logic                      w_aw_hs;
    logic                      w_ar_hs;
    logic                      w_wr_beat;
    logic                      w_rd_beat;
    logic                      w_unused;

    assign w_aw_idx = axi_bus.m_awaddr[ADDR_WIDTH+1:2];
    assign w_ar_idx = axi_bus.m_araddr[ADDR_WIDTH+1:2];

    // Bits that have no effect: upper/byte address bits, wlast, and wstrb in the full-word build.
    assign w_unused = ^{axi_bus.m_wlast, axi_bus.m_wstrb,
                        axi_bus.m_awaddr[31:ADDR_WIDTH+2], axi_bus.m_awaddr[1:0],
                        axi_bus.m_araddr[31:ADDR_WIDTH+2], axi_bus.m_araddr[1:0]};

    // State register; r_rst_done keeps the readies low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
        end
    end

    // Next-state decode and channel handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_awready    = 1'b0;
        w_arready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        w_rvalid     = 1'b0;
        w_rlast      = 1'b0;
        w_aw_hs      = 1'b0;
        w_ar_hs      = 1'b0;
        w_wr_beat    = 1'b0;
        w_rd_beat    = 1'b0;
        case (r_state)
            IDLE: begin
                w_awready = r_rst_done;
                w_arready = r_rst_done && !axi_bus.m_awvalid;
                w_aw_hs   = w_awready && axi_bus.m_awvalid;
                w_ar_hs   = w_arready && axi_bus.m_arvalid;
                if (w_aw_hs) begin
                    w_state_next = WRITE_BURST;
                end else if (w_ar_hs) begin
                    w_state_next = READ_BURST;
                end
            end
            WRITE_BURST: begin
                w_wready  = 1'b1;
                w_wr_beat = axi_bus.m_wvalid;
                if (w_wr_beat && (r_cnt == r_len)) begin
                    w_state_next = WRITE_RESP;
                end
            end
            WRITE_RESP: begin
                w_bvalid = 1'b1;
                if (axi_bus.m_bready) begin
                    w_state_next = IDLE;
                end
            end
            READ_BURST: begin
                w_rvalid  = 1'b1;
                w_rlast   = (r_cnt == r_len);
                w_rd_beat = axi_bus.m_rready;
                if (w_rd_beat && w_rlast) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Burst address/counter tracking and the registered read word.
    // The read word is prefetched one beat ahead so r_addr always points past s_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else if (w_aw_hs) begin
            r_addr <= w_aw_idx;
            r_len  <= axi_bus.m_awlen;
            r_cnt  <= '0;
        end else if (w_ar_hs) begin
            r_addr  <= w_ar_idx + ADDR_WIDTH'(1);
            r_len   <= axi_bus.m_arlen;
            r_cnt   <= '0;
            r_rdata <= r_mem[w_ar_idx];
        end else if (w_wr_beat) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_cnt  <= r_cnt + 8'd1;
        end else if (w_rd_beat && !w_rlast) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_cnt   <= r_cnt + 8'd1;
            r_rdata <= r_mem[r_addr];
        end
    end

    // SRAM write port; a beat presented in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_beat && !reset) begin
`ifdef AXI_SRAM_WRITE_STROBE_EN
            for (int unsigned b = 0; b < AXI_DATA_WIDTH / 8; b++) begin
                if (axi_bus.m_wstrb[b]) begin
                    r_mem[r_addr][b*8 +: 8] <= axi_bus.m_wdata[b*8 +: 8];
                end
            end
`else
            r_mem[r_addr] <= axi_bus.m_wdata;
`endif
        end
    end

    assign axi_bus.s_awready = w_awready;
    assign axi_bus.s_arready = w_arready;
    assign axi_bus.s_wready  = w_wready;
    assign axi_bus.s_bvalid  = w_bvalid;
    assign axi_bus.s_rvalid  = w_rvalid;
    assign axi_bus.s_rlast   = w_rlast;
    assign axi_bus.s_rdata   = r_rdata;
endmodule
